uart_rx_baud: RTL and testbench

UART receive path that pairs with the existing transmitter/display top level. It deserialises an 8N1 serial line at one of four selectable baud rates using 16x oversampling and delivers each received byte with a single-cycle valid strobe. The byte output feeds the seven-segment display driver, giving a loopback path from the transmitter's serial output. It also flags framing errors and waits out break conditions on the line.

---
 rtl/uart_rx_baud.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_baud.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_baud.sv
// ---------------------------------------------------------------------------
// uart_rx_baud
//
// 8N1 UART receiver with 16x oversampling and four selectable baud rates.
// Each received byte is presented on data_out together with a single-cycle
// rx_valid strobe. A bad stop bit raises frame_error (held until the next good
// frame). After a framing error the receiver waits for the line to return
// high, so a break condition does not produce a stream of bogus frames.
//
// The default divisors assume a 50 MHz system clock.
//
// Parameters:
//   DIV_2400   clock cycles per oversample tick at baud_select = 2'b00
//   DIV_4800   clock cycles per oversample tick at baud_select = 2'b01
//   DIV_9600   clock cycles per oversample tick at baud_select = 2'b10
//   DIV_19200  clock cycles per oversample tick at baud_select = 2'b11
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   rx           serial input, idle high, asynchronous to clk
//   baud_select  rate select, sampled only when a start bit is detected
//   data_out     last correctly received byte
//   rx_valid     one-cycle pulse when data_out is updated
//   frame_error  set on a bad stop bit, cleared by the next good frame
//   busy         high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_baud #(
   parameter int DIV_2400  = 1302,
   parameter int DIV_4800  = 651,
   parameter int DIV_9600  = 325,
   parameter int DIV_19200 = 162
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic [1:0] baud_select,
   output logic [7:0] data_out,
   output logic       rx_valid,
   output logic       frame_error,
   output logic       busy
);

   localparam int CW = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t        state_q, state_d;
   logic          rx_meta_q, rxs_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] div_q, div_d;
   logic [CW-1:0] div_sel;
   logic [3:0]    ovs_q, ovs_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          tick;

   // Divisor for the currently requested rate; only captured at start detect.
   always_comb begin
      div_sel = CW'(DIV_2400);
      case (baud_select)
         2'b00:   div_sel = CW'(DIV_2400);
         2'b01:   div_sel = CW'(DIV_4800);
         2'b10:   div_sel = CW'(DIV_9600);
         default: div_sel = CW'(DIV_19200);
      endcase
   end

   // Oversample tick: acted on at the edge where the counter wraps.
   assign tick = (cnt_q == div_q - CW'(1));

   always_comb begin
      state_d = state_q;
      cnt_d   = tick ? '0 : cnt_q + CW'(1);
      ovs_d   = tick ? ovs_q + 4'd1 : ovs_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      div_d   = div_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = ferr_q;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            ovs_d = '0;
            if (!rxs_q) begin
               state_d = S_START;
               div_d   = div_sel;
            end
         end
         S_START: begin
            // 8th tick lands mid start bit; a high line here was a glitch.
            if (tick && ovs_q == 4'd7) begin
               state_d = rxs_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            // ovs wraps 15 -> 0 by itself, so each bit is 16 ticks apart.
            if (tick && ovs_q == 4'd15) begin
               shift_d = {rxs_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (tick && ovs_q == 4'd15) begin
               if (rxs_q) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  ferr_d  = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_WAIT_IDLE;
               end
            end
         end
         S_WAIT_IDLE: begin
            if (rxs_q) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Every state entry starts timing from a clean slate.
      if (state_d != state_q) begin
         cnt_d = '0;
         ovs_d = '0;
         bit_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
         cnt_q     <= '0;
         div_q     <= CW'(DIV_2400);
         ovs_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rx_meta_q <= rx;
         rxs_q     <= rx_meta_q;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         ovs_q     <= ovs_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   assign data_out    = data_q;
   assign rx_valid    = valid_q;
   assign frame_error = ferr_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_baud.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_baud
//
// Drives 8N1 frames on rx with small divisors (32/16/8/4 cycles per tick) and
// checks decoded bytes, strobe timing, framing errors, busy and reset against
// a frame-level model: every good frame queues its byte and the cycle its
// strobe is due (start detect + 152 ticks); a monitor matches strobes to it.
// ---------------------------------------------------------------------------
module tb_uart_rx_baud;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx = 1'b1;
   logic [1:0] baud_select = 2'b11;
   logic [7:0] data_out;
   logic       rx_valid;
   logic       frame_error;
   logic       busy;

   uart_rx_baud #(
      .DIV_2400 (32),
      .DIV_4800 (16),
      .DIV_9600 (8),
      .DIV_19200(4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .baud_select(baud_select),
      .data_out   (data_out),
      .rx_valid   (rx_valid),
      .frame_error(frame_error),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   typedef struct {
      logic [7:0] data;
      int         at;
   } exp_t;

   exp_t exp_q[$];
   logic prev_valid = 1'b0;

   function automatic int div_of(input logic [1:0] sel);
      case (sel)
         2'b00:   return 32;
         2'b01:   return 16;
         2'b10:   return 8;
         default: return 4;
      endcase
   endfunction

   // Strobe monitor: every pulse must match the oldest queued frame exactly.
   always @(negedge clk) begin : mon
      exp_t e;
      if (!reset) begin
         exp_q.delete();
         prev_valid <= 1'b0;
      end else begin
         if (prev_valid) check_eq("valid_width", rx_valid, 0);
         if (rx_valid) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_valid", rx_valid, 0);
            end else begin
               e = exp_q.pop_front();
               check_eq("valid_cycle", cyc, e.at);
               check_eq("data_out", data_out, e.data);
               check_eq("ferr_on_valid", frame_error, 0);
            end
         end else if (exp_q.size() > 0 && cyc > exp_q[0].at) begin
            check_eq("valid_missing", rx_valid, 1);
            void'(exp_q.pop_front());
         end
         prev_valid <= rx_valid;
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Sends one full frame; called at a falling edge. The stop bit is driven
   // with stop_ok, so a bad frame leaves the line low afterwards.
   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input logic [1:0] sel,
                             input int sw_bit, input logic [1:0] sw_sel);
      int   d;
      exp_t e;
      baud_select = sel;
      d = div_of(sel);
      rx = 1'b0;
      // Two synchroniser edges, then IDLE->START on the third edge.
      if (stop_ok) begin
         e.data = b;
         e.at   = cyc + 3 + 152 * d;
         exp_q.push_back(e);
      end
      wait_cyc(16 * d);
      for (int i = 0; i < 8; i++) begin
         if (i == sw_bit) baud_select = sw_sel;
         rx = b[i];
         wait_cyc(16 * d);
      end
      rx = stop_ok;
      wait_cyc(16 * d);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp_data;
      bit         exp_ferr;
      logic [7:0] rb;
      logic [1:0] rsel;
      bit         rok;
      logic [7:0] abort_byte;

      // Reset state
      wait_cyc(3);
      check_eq("rst_data", data_out, 8'h00);
      check_eq("rst_valid", rx_valid, 0);
      check_eq("rst_ferr", frame_error, 0);
      check_eq("rst_busy", busy, 0);
      reset = 1'b1;
      wait_cyc(3);

      // 0xA5 at 19200
      send_frame(8'hA5, 1'b1, 2'b11, -1, 2'b00);
      wait_cyc(2);
      check_eq("a5_data", data_out, 8'hA5);
      check_eq("a5_ferr", frame_error, 0);
      check_eq("a5_busy", busy, 0);
      $display("[TB] frame 0xA5 @19200 done, data_out=0x%0h", data_out);

      // Start-bit glitch: 8 cycles low
      rx = 1'b0;
      wait_cyc(8);
      rx = 1'b1;
      wait_cyc(6);
      check_eq("glitch_busy_hi", busy, 1);
      wait_cyc(22);
      check_eq("glitch_busy_lo", busy, 0);
      check_eq("glitch_data", data_out, 8'hA5);
      $display("[TB] glitch rejected, busy=%0d", busy);

      // Framing error followed by break, then recovery
      send_frame(8'h3C, 1'b0, 2'b11, -1, 2'b00);
      wait_cyc(20 * 64);
      check_eq("brk_ferr", frame_error, 1);
      check_eq("brk_busy", busy, 1);
      check_eq("brk_data", data_out, 8'hA5);
      rx = 1'b1;
      wait_cyc(5);
      check_eq("brk_release_busy", busy, 0);
      check_eq("brk_release_ferr", frame_error, 1);
      send_frame(8'h81, 1'b1, 2'b11, -1, 2'b00);
      wait_cyc(2);
      check_eq("rec_data", data_out, 8'h81);
      check_eq("rec_ferr", frame_error, 0);
      $display("[TB] break handled, recovered data_out=0x%0h", data_out);

      // Back-to-back frames at 2400
      send_frame(8'h00, 1'b1, 2'b00, -1, 2'b00);
      send_frame(8'hFF, 1'b1, 2'b00, -1, 2'b00);
      wait_cyc(2);
      check_eq("b2b_data", data_out, 8'hFF);
      check_eq("b2b_ferr", frame_error, 0);
      $display("[TB] back-to-back 0x00/0xFF done, data_out=0x%0h", data_out);

      // Reset during bit 4 at 9600
      abort_byte = 8'h96;
      baud_select = 2'b10;
      rx = 1'b0;
      wait_cyc(128);
      for (int i = 0; i < 4; i++) begin
         rx = abort_byte[i];
         wait_cyc(128);
      end
      rx = abort_byte[4];
      wait_cyc(64);
      check_eq("mid_busy", busy, 1);
      reset = 1'b0;
      #1;
      check_eq("arst_data", data_out, 8'h00);
      check_eq("arst_valid", rx_valid, 0);
      check_eq("arst_ferr", frame_error, 0);
      check_eq("arst_busy", busy, 0);
      @(negedge clk);
      rx = 1'b1;
      wait_cyc(3);
      reset = 1'b1;
      wait_cyc(3);
      send_frame(8'h5A, 1'b1, 2'b10, -1, 2'b00);
      wait_cyc(2);
      check_eq("post_rst_data", data_out, 8'h5A);
      $display("[TB] reset mid-frame, then 0x5A: data_out=0x%0h", data_out);

      // Baud change mid-frame only affects the next frame
      send_frame(8'hC3, 1'b1, 2'b01, 2, 2'b11);
      check_eq("sw_sel_seen", baud_select, 2'b11);
      send_frame(8'h3C, 1'b1, 2'b11, -1, 2'b00);
      wait_cyc(2);
      check_eq("sw_next_data", data_out, 8'h3C);
      $display("[TB] baud switch: 0xC3 @4800 then 0x3C @19200, data_out=0x%0h", data_out);

      // Random frames
      exp_data = 8'h3C;
      exp_ferr = 1'b0;
      for (int k = 0; k < 8; k++) begin
         rb   = 8'($urandom);
         rsel = 2'($urandom_range(0, 3));
         rok  = ($urandom_range(0, 3) != 0);
         wait_cyc($urandom_range(1, 20));
         send_frame(rb, rok, rsel, -1, 2'b00);
         if (rok) begin
            exp_data = rb;
            exp_ferr = 1'b0;
            wait_cyc(2);
         end else begin
            exp_ferr = 1'b1;
            wait_cyc($urandom_range(1, 2) * 16 * div_of(rsel));
            check_eq("rnd_break_busy", busy, 1);
            rx = 1'b1;
            wait_cyc(5);
         end
         check_eq("rnd_data", data_out, exp_data);
         check_eq("rnd_ferr", frame_error, exp_ferr);
         check_eq("rnd_busy", busy, 0);
         $display("[TB] random frame %0d: byte=0x%0h sel=%0d stop_ok=%0d data_out=0x%0h ferr=%0d",
                  k, rb, rsel, rok, data_out, frame_error);
      end

      wait_cyc(10);
      check_eq("pending_frames", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
